// File: rtl/thinning_pkg.sv
// Shared types and width constants for the thinning pass sequencer.
package thinning_pkg;
    localparam int N_DEF           = 8;
    localparam int BIT_SIZE_DEF    = 6;
    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int MAX_PASSES_DEF  = 15;
    localparam int SLOT_CYCLES     = 2;
    localparam int ADDR_W          = $clog2(N_DEF * N_DEF) + 1;
    localparam int PIX_W           = PIXEL_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        CHECK,
        DONE
    } seq_state_t;
endpackage

// File: rtl/thinning_pass_sequencer_pixel_slot_counter.sv
// Walks pixel slots of SLOT_CYCLES cycles each, stopping at a terminal slot index.
module pixel_slot_counter
    import thinning_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] terminal,
    output logic [ADDR_WIDTH-1:0] slot,
    output logic                  phase,
    output logic                  last
);
    localparam int PH_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [PH_W-1:0] ph_q;

    // phase is high on the final cycle of a slot
    assign phase = (ph_q == PH_W'(SLOT_CYCLES - 1));
    assign last  = phase && (slot == terminal);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot <= '0;
            ph_q <= '0;
        end else if (en) begin
            if (phase) begin
                ph_q <= '0;
                if (slot != terminal) begin
                    slot <= slot + 1'b1;
                end
            end else begin
                ph_q <= ph_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/thinning_pass_sequencer.sv
// Repeats broadcast/collect thinning passes over the frame memory until
// a pass changes no pixel or the pass limit is hit.
module thinning_pass_sequencer
    import thinning_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int BIT_SIZE    = BIT_SIZE_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int MAX_PASSES  = MAX_PASSES_DEF,
    localparam int PASS_W     = $clog2(MAX_PASSES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [PASS_W-1:0]      pass_count,
    output logic [BIT_SIZE:0]      change_count,
    output logic [BIT_SIZE:0]      mem_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_rdata,
    output logic                   mem_we,
    output logic [PIXEL_WIDTH-1:0] mem_wdata,
    output logic                   k_we,
    output logic [BIT_SIZE:0]      k_addr,
    output logic [PIXEL_WIDTH-1:0] k_data,
    input  logic [PIXEL_WIDTH-1:0] k_result
);
    localparam int AW = BIT_SIZE + 1;
    localparam logic [AW-1:0] NPIX = AW'(N * N);

    seq_state_t state_q, state_d;

    logic [AW-1:0]          slot;
    logic                   phase;
    logic                   last;
    logic [AW-1:0]          terminal;
    logic                   cnt_clear;
    logic                   cnt_en;

    logic [PIXEL_WIDTH-1:0] kdata_q;
    logic [PIXEL_WIDTH-1:0] wdata_q;
    logic [AW-1:0]          chg_q;
    logic [PASS_W-1:0]      pass_q;
    logic [PASS_W-1:0]      pass_next;
    logic [AW-1:0]          change_q;
    logic                   conv_q;

    assign pass_next = pass_q + 1'b1;
    assign terminal  = (state_q == LOAD) ? NPIX : NPIX - 1'b1;
    assign cnt_en    = (state_q == LOAD) || (state_q == READ);
    assign cnt_clear = (state_d != state_q);

    pixel_slot_counter #(
        .ADDR_WIDTH(AW)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .terminal(terminal),
        .slot    (slot),
        .phase   (phase),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  if (last) state_d = READ;
            READ:  if (last) state_d = CHECK;
            CHECK: begin
                if (chg_q == '0 || pass_next == PASS_W'(MAX_PASSES)) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kdata_q  <= '0;
            wdata_q  <= '0;
            chg_q    <= '0;
            pass_q   <= '0;
            change_q <= '0;
            conv_q   <= 1'b0;
        end else begin
            wdata_q <= k_result;
            // read data for slot s lands in its second cycle; it is broadcast in slot s+1
            if (state_q == LOAD && phase) begin
                kdata_q <= mem_rdata;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        chg_q  <= '0;
                        pass_q <= '0;
                        conv_q <= 1'b0;
                    end
                end
                READ: begin
                    if (phase && wdata_q != mem_rdata && chg_q != {AW{1'b1}}) begin
                        chg_q <= chg_q + 1'b1;
                    end
                end
                CHECK: begin
                    pass_q   <= pass_next;
                    change_q <= chg_q;
                    conv_q   <= (chg_q == '0);
                    if (state_d == LOAD) begin
                        chg_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from flops only; k_result reaches mem_wdata through wdata_q.
    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        converged    = conv_q;
        pass_count   = pass_q;
        change_count = change_q;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        k_we         = 1'b0;
        k_addr       = '0;
        k_data       = '0;
        if (state_q == LOAD) begin
            if (slot < NPIX) begin
                mem_addr = slot;
            end
            if (slot != '0) begin
                k_we   = 1'b1;
                k_addr = slot - 1'b1;
                k_data = kdata_q;
            end
        end else if (state_q == READ) begin
            mem_addr = slot;
            k_addr   = slot;
            if (phase) begin
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
            end
        end
    end
endmodule

// File: doc/thinning_pass_sequencer.md
# thinning_pass_sequencer

Sequences repeated thinning passes over the N×N frame memory through the bank of 3×3 convolution units. Each pass has two phases. First it broadcasts every pixel to the units with `k_we` high (write phase). Then it sweeps addresses with `k_we` low to collect the merged results and write them back to frame memory, counting changed pixels. Passes repeat until a pass changes nothing or `MAX_PASSES` is reached. The block sits between the frame memory and the convolution-unit bank, and is the only master of both.

## Interface
- `N`, 8, image side length; frame holds N*N pixels
- `BIT_SIZE`, 6, address MSB index; addresses are `[BIT_SIZE:0]`
- `PIXEL_WIDTH`, 8, pixel width
- `MAX_PASSES`, 15, pass limit; `PASS_W = $clog2(MAX_PASSES+1)`

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a thinning run; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted through DONE
- `done`  out  1  one-cycle pulse in DONE
- `converged`  out  1  valid with `done`; held until next start
- `pass_count`  out  PASS_W  passes completed in current/last run
- `change_count`  out  BIT_SIZE+1  changed pixels in last completed pass
- `mem_addr`  out  BIT_SIZE+1  frame memory address
- `mem_rdata`  in  PIXEL_WIDTH  read data, valid one cycle after `mem_addr`
- `mem_we`  out  1  frame memory write enable
- `mem_wdata`  out  PIXEL_WIDTH  write data
- `k_we`  out  1  convolution bank write phase
- `k_addr`  out  BIT_SIZE+1  pixel position broadcast to bank
- `k_data`  out  PIXEL_WIDTH  pixel value broadcast to bank
- `k_result`  in  PIXEL_WIDTH  merged bank result for `k_addr`, valid by the second cycle of a slot

## Operation
- Convolution units act on alternate clock edges, so every pixel occupies a 2-cycle slot. Slot cycle 0 is the first cycle of the slot; slot cycle 1 is the second.
- States: IDLE, LOAD, READ, CHECK, DONE.
- IDLE:
  - All outputs 0 except `converged`, `pass_count` and `change_count`, which hold their values.
  - `start` = 1 → LOAD; clears `pass_count`, `converged` and the change counter.
- LOAD runs N*N+1 slots, s = 0..N*N:
  - Slot cycle 0, for s < N*N: `mem_addr` = s, and `mem_rdata` is registered at the end of the cycle.
  - Slots s ≥ 1: `k_we` = 1, `k_addr` = s-1, `k_data` = mem[s-1], all held stable for both cycles of the slot.
  - Slot 0: `k_we` = 0.
  - After the last slot → READ.
- READ runs N*N slots, i = 0..N*N-1:
  - `k_we` = 0, `k_addr` = i for both cycles.
  - Slot cycle 0: `mem_addr` = i, `mem_we` = 0.
  - Slot cycle 1: `mem_addr` = i, `mem_we` = 1, `mem_wdata` = `k_result`. If `k_result` ≠ `mem_rdata`, the change counter increments (saturating at 2^(BIT_SIZE+1)-1).
  - After the last slot → CHECK.
- CHECK, 1 cycle:
  - `pass_count` += 1 and `change_count` ← change counter.
  - If the counter is 0: `converged` = 1 → DONE.
  - Else if the new `pass_count` = MAX_PASSES: `converged` = 0 → DONE.
  - Else: clear the counter → LOAD.
- DONE, 1 cycle: `done` = 1 → IDLE.
- `start` while busy is ignored.
- `rst` at any point: next state is IDLE and every output is 0, including `converged`, `pass_count` and `change_count`. A write-back in flight is abandoned; `mem_we` is never high in the cycle after reset is sampled.

## Timing
- `start` sampled at edge 0. LOAD occupies cycles 1..2(N*N+1), then READ takes 2·N*N cycles, then CHECK for 1 cycle.
- N=8: LOAD 1..130, READ 131..258, CHECK 259, DONE (`done` = 1) 260.
- Each additional pass adds 259 cycles; the next LOAD starts the cycle after CHECK.
- `k_addr` lags the LOAD-phase `mem_addr` by exactly one slot (2 cycles).
- All outputs are registered; no combinational path from `k_result`/`mem_rdata` to outputs other than `mem_wdata`, which is registered from `k_result`.

## Structure
- Shared package `thinning_pkg`:
  - `seq_state_t` enum (IDLE, LOAD, READ, CHECK, DONE)
  - `SLOT_CYCLES = 2`
  - address/pixel width localparams derived from N and PIXEL_WIDTH
- Sub-module `pixel_slot_counter`:
  - produces slot index, slot-cycle phase bit and last-slot flag
  - takes a terminal count input: N*N for LOAD, N*N-1 for READ
  - synchronous clear from `rst` and on state entry

## Test plan
- Reset values: assert `rst` 3 cycles with `start` = 1. Required: all outputs 0 and state IDLE; after release with `start` low, nothing moves.
- Identity bank model (`k_result` = mem value), N=8:
  - `done` at cycle 260, `converged` = 1, `pass_count` = 1, `change_count` = 0.
  - Memory unchanged; `mem_we` high on exactly 64 cycles.
- Broadcast check: mem[i] = i+100. During LOAD, `k_addr` = i with `k_data` = i+100 for exactly 2 consecutive cycles at cycles 2i+3..2i+4; `k_we` = 0 during cycles 1..2.
- Model zeroes pixel 9 (initially 50) and is identity otherwise:
  - Pass 1 has `change_count` = 1; pass 2 has 0.
  - `converged` = 1, `pass_count` = 2, `done` at cycle 519, mem[9] = 0.
- Model that inverts every pixel, MAX_PASSES=3: `done` after pass 3 with `converged` = 0, `pass_count` = 3, `change_count` = 64 (saturation not reached).
- Busy/reset:
  - `start` pulsed at cycle 50 has no effect.
  - `rst` at READ slot 10, cycle 151: outputs 0 from cycle 152, `mem_we` low.
  - A new `start` then completes normally with `pass_count` = 1.
